// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the hsdaoh I2C init sequencer: FSM states, table-entry
// field layout and delay helpers.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    S_STARTUP,
    S_FETCH,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RETRY_WAIT,
    S_READY,
    S_HOST_DONE
  } seq_state_t;

  // A table entry whose device field equals this value terminates the walk.
  localparam int unsigned END_MARKER_DEVICE = 0;

  // Entries are packed {device, register, data}, data in the low bits.
  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned register_lsb(int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned device_lsb(int unsigned data_width, int unsigned register_width);
    return data_width + register_width;
  endfunction

  // The timer expires when it reaches zero, so an N-cycle delay loads N-1.
  function automatic int unsigned delay_load(int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter shared by the startup and retry delays; expired while
// the count sits at zero.
module i2c_seq_timer #(
  parameter int unsigned      WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// Drives the shared i2c_master: power-up delay, register-table walk with NACK
// retries, then single host transactions for the UART bridge.
module i2c_init_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REGISTER_WIDTH = 8,
  parameter int unsigned ADDRESS_WIDTH  = 7,
  parameter int unsigned NUM_ENTRIES    = 16,
  parameter int unsigned STARTUP_CYCLES = 1000,
  parameter int unsigned RETRY_CYCLES   = 500,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                                                 clock,
  input  logic                                                 reset_n,
  output logic [$clog2(NUM_ENTRIES)-1:0]                       table_index,
  input  logic [ADDRESS_WIDTH+REGISTER_WIDTH+DATA_WIDTH-1:0]   table_entry,
  output logic                                                 m_enable,
  output logic                                                 m_read_write,
  output logic [ADDRESS_WIDTH-1:0]                             m_device_address,
  output logic [REGISTER_WIDTH-1:0]                            m_register_address,
  output logic [DATA_WIDTH-1:0]                                m_mosi_data,
  input  logic                                                 m_busy,
  input  logic                                                 m_got_acknowledge,
  input  logic [DATA_WIDTH-1:0]                                m_miso_data,
  input  logic                                                 host_valid,
  output logic                                                 host_ready,
  input  logic                                                 host_read_write,
  input  logic [ADDRESS_WIDTH-1:0]                             host_device_address,
  input  logic [REGISTER_WIDTH-1:0]                            host_register_address,
  input  logic [DATA_WIDTH-1:0]                                host_mosi_data,
  output logic                                                 host_done,
  output logic                                                 host_ack,
  output logic [DATA_WIDTH-1:0]                                host_miso_data,
  output logic                                                 init_done,
  output logic                                                 init_error
);

  localparam int unsigned IDX_W     = $clog2(NUM_ENTRIES);
  localparam int unsigned MAX_DELAY = (STARTUP_CYCLES > RETRY_CYCLES) ? STARTUP_CYCLES : RETRY_CYCLES;
  localparam int unsigned TIMER_W   = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int unsigned RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int unsigned REG_LSB   = register_lsb(DATA_WIDTH);
  localparam int unsigned DEV_LSB   = device_lsb(DATA_WIDTH, REGISTER_WIDTH);

  localparam logic [TIMER_W-1:0] STARTUP_LOAD = TIMER_W'(delay_load(STARTUP_CYCLES));
  localparam logic [TIMER_W-1:0] RETRY_LOAD   = TIMER_W'(delay_load(RETRY_CYCLES));

  seq_state_t state, state_next;

  logic [ADDRESS_WIDTH-1:0]  entry_device;
  logic [REGISTER_WIDTH-1:0] entry_register;
  logic [DATA_WIDTH-1:0]     entry_data;
  logic [RETRY_W-1:0]        retry_count;
  logic                      host_txn;
  logic                      table_end;
  logic                      fetch_end;
  logic                      fetch_entry;
  logic                      accept_host;
  logic                      txn_end;
  logic                      timer_load;
  logic [TIMER_W-1:0]        timer_load_value;
  logic                      timer_expired;

  assign entry_device   = table_entry[DEV_LSB +: ADDRESS_WIDTH];
  assign entry_register = table_entry[REG_LSB +: REGISTER_WIDTH];
  assign entry_data     = table_entry[DATA_LSB +: DATA_WIDTH];

  // Reloading on every state change keeps one counter valid for both delays.
  assign timer_load       = (state_next != state);
  assign timer_load_value = (state_next == S_RETRY_WAIT) ? RETRY_LOAD : STARTUP_LOAD;

  i2c_seq_timer #(
    .WIDTH       (TIMER_W),
    .RESET_VALUE (STARTUP_LOAD)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_load_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_STARTUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    fetch_end   = 1'b0;
    fetch_entry = 1'b0;
    accept_host = 1'b0;
    txn_end     = 1'b0;
    case (state)
      S_STARTUP: begin
        if (timer_expired) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (table_end || (entry_device == ADDRESS_WIDTH'(END_MARKER_DEVICE))) begin
          fetch_end  = 1'b1;
          state_next = S_READY;
        end else if (!m_busy) begin
          fetch_entry = 1'b1;
          state_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (m_busy) state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!m_busy) begin
          txn_end = 1'b1;
          if (host_txn) begin
            state_next = S_HOST_DONE;
          end else if (!m_got_acknowledge && (retry_count < RETRY_W'(MAX_RETRIES))) begin
            state_next = S_RETRY_WAIT;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_RETRY_WAIT: begin
        if (timer_expired && !m_busy) state_next = S_ISSUE;
      end
      S_READY: begin
        if (host_valid && host_ready && !m_busy) begin
          accept_host = 1'b1;
          state_next  = S_ISSUE;
        end
      end
      S_HOST_DONE: begin
        state_next = S_READY;
      end
      default: begin
        state_next = S_STARTUP;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_enable           <= 1'b0;
      m_read_write       <= 1'b0;
      m_device_address   <= '0;
      m_register_address <= '0;
      m_mosi_data        <= '0;
      table_index        <= '0;
      table_end          <= 1'b0;
      retry_count        <= '0;
      host_txn           <= 1'b0;
      host_ready         <= 1'b0;
      host_done          <= 1'b0;
      host_ack           <= 1'b0;
      host_miso_data     <= '0;
      init_done          <= 1'b0;
      init_error         <= 1'b0;
    end else begin
      m_enable   <= (state_next == S_ISSUE);
      host_ready <= (state_next == S_READY);
      host_done  <= (state_next == S_HOST_DONE);
      if (fetch_entry) begin
        m_read_write       <= 1'b0;
        m_device_address   <= entry_device;
        m_register_address <= entry_register;
        m_mosi_data        <= entry_data;
        retry_count        <= '0;
        host_txn           <= 1'b0;
      end
      if (accept_host) begin
        m_read_write       <= host_read_write;
        m_device_address   <= host_device_address;
        m_register_address <= host_register_address;
        m_mosi_data        <= host_mosi_data;
        host_txn           <= 1'b1;
      end
      if (fetch_end) init_done <= 1'b1;
      if (txn_end) begin
        if (host_txn) begin
          host_ack       <= m_got_acknowledge;
          host_miso_data <= m_miso_data;
        end else if (!m_got_acknowledge && (retry_count < RETRY_W'(MAX_RETRIES))) begin
          retry_count <= retry_count + RETRY_W'(1);
        end else begin
          // Acked or out of retries: move on; the index saturates and the end flag takes over.
          if (!m_got_acknowledge) init_error <= 1'b1;
          if (table_index == IDX_W'(NUM_ENTRIES - 1)) begin
            table_end <= 1'b1;
          end else begin
            table_index <= table_index + IDX_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Randomized bench for i2c_init_sequencer: a queue-based expected-transaction
// model drives a responsive I2C master stand-in.
module tb_i2c_init_sequencer;

  localparam int unsigned DW   = 8;
  localparam int unsigned RGW  = 8;
  localparam int unsigned AW   = 7;
  localparam int unsigned NE   = 8;
  localparam int unsigned SC   = 20;
  localparam int unsigned RC   = 10;
  localparam int unsigned MR   = 3;
  localparam int unsigned IW   = $clog2(NE);
  localparam int unsigned EW   = AW + RGW + DW;
  localparam int unsigned OUTW = 7 + AW + RGW + 2 * DW + IW;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [IW-1:0]  table_index;
  logic [EW-1:0]  table_entry;
  logic           m_enable, m_read_write;
  logic [AW-1:0]  m_device_address;
  logic [RGW-1:0] m_register_address;
  logic [DW-1:0]  m_mosi_data;
  logic           m_busy = 1'b0;
  logic           m_got_acknowledge = 1'b0;
  logic [DW-1:0]  m_miso_data = '0;
  logic           host_valid, host_ready, host_read_write;
  logic [AW-1:0]  host_device_address;
  logic [RGW-1:0] host_register_address;
  logic [DW-1:0]  host_mosi_data;
  logic           host_done, host_ack;
  logic [DW-1:0]  host_miso_data;
  logic           init_done, init_error;
  logic [OUTW-1:0] out_vec;

  logic [EW-1:0] tbl [NE];
  assign table_entry = tbl[table_index];
  assign out_vec = {m_enable, m_read_write, m_device_address, m_register_address, m_mosi_data,
                    table_index, host_ready, host_done, host_ack, host_miso_data, init_done, init_error};

  always #5 clock = ~clock;

  i2c_init_sequencer #(
    .DATA_WIDTH(DW), .REGISTER_WIDTH(RGW), .ADDRESS_WIDTH(AW), .NUM_ENTRIES(NE),
    .STARTUP_CYCLES(SC), .RETRY_CYCLES(RC), .MAX_RETRIES(MR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .table_index(table_index), .table_entry(table_entry),
    .m_enable(m_enable), .m_read_write(m_read_write), .m_device_address(m_device_address),
    .m_register_address(m_register_address), .m_mosi_data(m_mosi_data), .m_busy(m_busy),
    .m_got_acknowledge(m_got_acknowledge), .m_miso_data(m_miso_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_read_write(host_read_write),
    .host_device_address(host_device_address), .host_register_address(host_register_address),
    .host_mosi_data(host_mosi_data), .host_done(host_done), .host_ack(host_ack),
    .host_miso_data(host_miso_data), .init_done(init_done), .init_error(init_error)
  );

  typedef struct {
    bit             host;
    logic           rw;
    logic [AW-1:0]  dev;
    logic [RGW-1:0] rg;
    logic [DW-1:0]  data;
    logic           ack;
    logic [DW-1:0]  miso;
    bit             retry_next;
  } txn_t;

  txn_t exp_q[$];
  txn_t done_q[$];

  int unsigned total = 0, bad = 0;
  int unsigned cyc = 0, rel_cyc = 0, first_en_cyc = 0, fall_cyc = 0;
  int unsigned en_count = 0, busy_left = 0, done_count = 0, accept_count = 0, ready_early = 0;
  int unsigned exp_attempts = 0, exp_idx = 0;
  int unsigned nacks [NE];
  bit          exp_err = 0, expect_retry = 0, ready_expect = 0;
  txn_t        cur;

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Master stand-in: busy for a few cycles per enable, answers from the expected queue.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_busy = 1'b0; busy_left = 0; m_got_acknowledge = 1'b0; expect_retry = 0;
    end else if (busy_left > 0) begin
      if (m_enable) check_eq("enable_one_cycle", 1, 0);
      busy_left--;
      if (busy_left == 0) begin
        check_eq("hold_device", m_device_address, cur.dev);
        check_eq("hold_register", m_register_address, cur.rg);
        m_busy = 1'b0; m_got_acknowledge = cur.ack; m_miso_data = cur.miso;
        fall_cyc = cyc;
        expect_retry = !cur.host && cur.retry_next;
        if (cur.host) done_q.push_back(cur);
      end
    end else if (m_enable) begin
      en_count++;
      if (en_count == 1) first_en_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_enable", 1, 0);
        cur.host = 0; cur.ack = 1'b1; cur.retry_next = 0;
        cur.dev = m_device_address; cur.rg = m_register_address;
      end else begin
        cur = exp_q.pop_front();
        check_eq("rw", m_read_write, cur.rw);
        check_eq("device", m_device_address, cur.dev);
        check_eq("register", m_register_address, cur.rg);
        check_eq("mosi", m_mosi_data, cur.data);
        if (expect_retry) check_eq("retry_gap", cyc - fall_cyc, RC + 1);
      end
      m_busy = 1'b1; m_got_acknowledge = 1'b0;
      busy_left = $urandom_range(2, 5);
    end
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      ready_expect = 0;
    end else begin
      if (ready_expect) begin
        check_eq("ready_after_done", host_ready, 1);
        ready_expect = 0;
      end
      if (host_done) begin
        done_count++;
        ready_expect = 1;
        if (done_q.size() == 0) check_eq("spurious_done", 1, 0);
        else begin
          txn_t t;
          t = done_q.pop_front();
          check_eq("host_ack", host_ack, t.ack);
          check_eq("host_miso", host_miso_data, t.miso);
        end
      end
      if (host_ready && !init_done) ready_early++;
      if (host_ready && host_valid) accept_count++;
    end
  end

  // Builds a random table and the transaction list the walk must produce.
  task automatic prepare(input int unsigned n, input int unsigned nacks_max, input int forced_nacks0, input int forced_dev0);
    logic [AW-1:0] dev;
    txn_t t;
    @(negedge clock);
    reset_n = 1'b0; host_valid = 1'b0;
    exp_q.delete(); done_q.delete();
    exp_attempts = 0; exp_err = 0;
    for (int unsigned i = 0; i < NE; i++) begin
      dev = AW'($urandom_range(1, (1 << AW) - 1));
      if (i == 0 && forced_dev0 >= 0) dev = AW'(forced_dev0);
      if (i == n) dev = '0;
      tbl[i] = {dev, RGW'($urandom), DW'($urandom)};
      nacks[i] = $urandom_range(0, nacks_max);
      if (i == 0 && forced_nacks0 >= 0) nacks[0] = unsigned'(forced_nacks0);
    end
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned a = 0; a <= MR && a <= nacks[i]; a++) begin
        t.host = 0; t.rw = 1'b0;
        t.dev = tbl[i][EW-1 -: AW]; t.rg = tbl[i][DW +: RGW]; t.data = tbl[i][DW-1:0];
        t.ack = (a >= nacks[i]); t.miso = DW'($urandom);
        t.retry_next = !t.ack && (a < MR);
        exp_q.push_back(t);
        exp_attempts++;
      end
      if (nacks[i] > MR) exp_err = 1;
    end
    exp_idx = (n < NE) ? n : NE - 1;
    repeat (2) @(negedge clock);
  endtask

  task automatic release_dut();
    @(negedge clock);
    en_count = 0;
    reset_n = 1'b1;
    rel_cyc = cyc + 1;
  endtask

  task automatic finish_init();
    int unsigned b = 0;
    int unsigned budget = SC + exp_attempts * (RC + 16) + 100;
    while (!init_done && b < budget) begin @(negedge clock); b++; end
    check_eq("init_done", init_done, 1);
    check_eq("init_error", init_error, exp_err);
    check_eq("final_index", table_index, exp_idx);
    check_eq("attempts", en_count, exp_attempts);
    check_eq("unserved", exp_q.size(), 0);
    if (exp_attempts > 0) check_eq("startup_delay", first_en_cyc - rel_cyc, SC);
    repeat (6) @(negedge clock);
    check_eq("quiet_after_init", en_count, exp_attempts);
  endtask

  task automatic host_txn(input logic rw, input logic [AW-1:0] dev, input logic [RGW-1:0] rg,
                          input logic [DW-1:0] data, input logic ack, input logic [DW-1:0] miso);
    txn_t t;
    int unsigned b, dc0;
    t.host = 1; t.rw = rw; t.dev = dev; t.rg = rg; t.data = data; t.ack = ack; t.miso = miso; t.retry_next = 0;
    exp_q.push_back(t);
    dc0 = done_count;
    @(negedge clock);
    host_read_write = rw; host_device_address = dev; host_register_address = rg;
    host_mosi_data = data; host_valid = 1'b1;
    b = 0;
    while (!host_ready && b < 50) begin @(negedge clock); b++; end
    check_eq("host_ready_seen", host_ready, 1);
    @(negedge clock);
    host_valid = 1'b0;
    check_eq("ready_drop", host_ready, 0);
    check_eq("enable_after_accept", m_enable, 1);
    b = 0;
    while (done_count == dc0 && b < 50) begin @(negedge clock); b++; end
    @(negedge clock);
    check_eq("host_done_count", done_count, dc0 + 1);
    check_eq("host_unserved", exp_q.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b, dc0;
    txn_t t;
    reset_n = 1'b0; host_valid = 1'b0; host_read_write = 1'b0;
    host_device_address = '0; host_register_address = '0; host_mosi_data = '0;
    for (int unsigned i = 0; i < NE; i++) tbl[i] = '0;
    repeat (3) @(negedge clock);
    check_eq("reset_values", out_vec, 0);

    // Two entries plus end marker, always acked.
    prepare(2, 0, -1, -1); release_dut(); finish_init();
    // Entry 0 nacked twice, then acked.
    prepare(3, 0, 2, -1); release_dut(); finish_init();
    // Device 0x50 never acks.
    prepare(3, 0, 9, 'h50); release_dut(); finish_init();
    // Random tables, including an empty one and a full walk with no marker.
    prepare(0, 5, -1, -1); release_dut(); finish_init();
    prepare(NE, 5, -1, -1); release_dut(); finish_init();
    repeat (4) begin
      prepare($urandom_range(1, NE), 5, -1, -1); release_dut(); finish_init();
    end

    host_txn(1'b1, 7'h21, 8'h12, DW'($urandom), 1'b1, 8'hA5);
    repeat (4) host_txn(1'($urandom), AW'($urandom), RGW'($urandom), DW'($urandom), 1'($urandom), DW'($urandom));

    // Reset while the master is busy on entry 1.
    prepare(4, 0, -1, -1); release_dut();
    b = 0;
    do begin @(negedge clock); #1; b++; end while (!(en_count >= 2 && m_busy) && b < 500);
    check_eq("busy_on_entry1", table_index, 1);
    reset_n = 1'b0;
    #1;
    check_eq("reset_outputs", out_vec, 0);
    prepare(4, 0, -1, -1); release_dut(); finish_init();

    // host_valid held high from reset: host work only after init, one per ready cycle.
    prepare(3, 1, -1, -1);
    host_valid = 1'b1; host_read_write = 1'b1;
    host_device_address = 7'h33; host_register_address = 8'h44; host_mosi_data = 8'h55;
    for (int unsigned k = 0; k < 3; k++) begin
      t.host = 1; t.rw = 1'b1; t.dev = 7'h33; t.rg = 8'h44; t.data = 8'h55;
      t.ack = 1'($urandom); t.miso = DW'($urandom); t.retry_next = 0;
      exp_q.push_back(t);
    end
    accept_count = 0; ready_early = 0; dc0 = done_count;
    release_dut();
    b = 0;
    while (done_count < dc0 + 3 && b < 2000) begin @(negedge clock); b++; end
    host_valid = 1'b0;
    repeat (6) @(negedge clock);
    check_eq("gating_ready_early", ready_early, 0);
    check_eq("gating_accepts", accept_count, 3);
    check_eq("gating_done", done_count, dc0 + 3);
    check_eq("gating_unserved", exp_q.size(), 0);
    check_eq("gating_init_error", init_error, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
